// File: rtl/data_mem_unit.sv
// MEM-stage data memory: word RAM, free-running CYCLE counter, and a byte TX FIFO,
// with sticky fault flags (misaligned, overflow) visible through STATUS.
module data_mem_unit #(
    parameter int RAM_WORDS = 256,
    parameter int TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MMemRead,
    input  logic        MMemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteMem,
    output logic [31:0] DataMemOut,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_fault
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0008;

    logic [RAM_WORDS-1:0][31:0] ram;
    logic [TXQ_DEPTH-1:0][7:0]  txq;
    logic [31:0]                cycle_cnt;
    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [CW-1:0]              count;
    logic                       mis;
    logic                       ovf;

    logic          access;
    logic          misaligned;
    logic          hit_ram;
    logic          hit_cycle;
    logic          hit_status;
    logic          hit_tx;
    logic [AW-1:0] ram_idx;
    logic          wr_ok;
    logic          ram_we;
    logic          tx_push_req;
    logic          status_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tx_pop;
    logic          push_ok;
    logic          ovf_set;
    logic          mis_set;
    logic [3:0]    count4;
    logic [31:0]   status_word;

    // Address decode; register hits compare the full address so low bits must be 00.
    always_comb begin
        access     = MMemRead | MMemWrite;
        misaligned = access && (DataAddr[1:0] != 2'b00);
        hit_ram    = (DataAddr[31:AW+2] == '0);
        hit_cycle  = (DataAddr == CYCLE_ADDR);
        hit_tx     = (DataAddr == TXDATA_ADDR);
        hit_status = (DataAddr == STATUS_ADDR);
        ram_idx    = DataAddr[AW+1:2];
    end

    always_comb begin
        wr_ok       = MMemWrite && !misaligned && !rst;
        ram_we      = wr_ok && hit_ram;
        tx_push_req = wr_ok && hit_tx;
        status_wr   = wr_ok && hit_status;
        fifo_full   = (count == CW'(TXQ_DEPTH));
        fifo_empty  = (count == '0);
        tx_pop      = tx_valid && tx_ready;
        // A pop on the same edge frees the slot the push needs.
        push_ok     = tx_push_req && (!fifo_full || tx_pop);
        ovf_set     = tx_push_req && fifo_full && !tx_pop;
        mis_set     = misaligned && !rst;
    end

    always_comb begin
        count4      = 4'(count);
        status_word = {24'b0, count4, ovf, mis, fifo_full, fifo_empty};
    end

    always_comb begin
        DataMemOut = '0;
        if (MMemRead && !misaligned) begin
            if (hit_ram) begin
                DataMemOut = ram[ram_idx];
            end else if (hit_cycle) begin
                DataMemOut = cycle_cnt;
            end else if (hit_status) begin
                DataMemOut = status_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram <= '0;
        end else if (ram_we) begin
            ram[ram_idx] <= WriteMem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            txq[wr_ptr] <= WriteMem[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, tx_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set events win over a same-cycle STATUS clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (mis_set) begin
                mis <= 1'b1;
            end else if (status_wr) begin
                mis <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (status_wr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_valid  = !rst && (count != '0);
        tx_data   = txq[rd_ptr];
        mem_fault = !rst && (mis | ovf);
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboarded random + directed bench for data_mem_unit against a queue/array reference model.
module tb_data_mem_unit;

    localparam logic [31:0] CYC_A = 32'hFFFF_0000;
    localparam logic [31:0] TX_A  = 32'hFFFF_0004;
    localparam logic [31:0] ST_A  = 32'hFFFF_0008;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MMemRead;
    logic        MMemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteMem;
    logic [31:0] DataMemOut;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_fault;

    data_mem_unit #(.RAM_WORDS(256), .TXQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .MMemRead(MMemRead), .MMemWrite(MMemWrite),
        .DataAddr(DataAddr), .WriteMem(WriteMem), .DataMemOut(DataMemOut),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_cyc;
    logic        m_mis;
    logic        m_ovf;
    logic [7:0]  mq[$];
    logic [7:0]  exp_q[$];

    logic [31:0] g;
    logic [31:0] g1;
    logic [31:0] g2;
    logic [7:0]  mon_exp;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        if (!rd || a[1:0] != 2'b00) return 32'h0;
        if (a < 32'd1024) return m_mem[a[9:2]];
        if (a == CYC_A) return m_cyc;
        if (a == ST_A) return {24'b0, 4'(mq.size()), m_ovf, m_mis,
                               mq.size() == DEPTH, mq.size() == 0};
        return 32'h0;
    endfunction

    // Monitor: every handshake the DUT presents must deliver the oldest accepted byte.
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%h required=none", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check32("tx_data", {24'b0, tx_data}, {24'b0, mon_exp});
            end
        end
    end

    task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy, output logic [31:0] got);
        logic mset;
        logic clr;
        logic push;
        logic oset;
        @(posedge clk);
        #1;
        rst = r; MMemRead = rd; MMemWrite = wr; DataAddr = a; WriteMem = wd; tx_ready = rdy;
        @(negedge clk);
        got = DataMemOut;
        if (!r) check32("rdata", DataMemOut, model_read(rd, a));
        check32("tx_valid", {31'b0, tx_valid}, {31'b0, (!r && mq.size() != 0)});
        check32("mem_fault", {31'b0, mem_fault}, {31'b0, (!r && (m_mis || m_ovf))});
        if (r) begin
            mq.delete();
            exp_q.delete();
            m_cyc = 0;
            m_mis = 0;
            m_ovf = 0;
            for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        end else begin
            mset = (rd || wr) && (a[1:0] != 2'b00);
            clr = 0;
            push = 0;
            oset = 0;
            if (wr && !mset) begin
                if (a < 32'd1024) m_mem[a[9:2]] = wd;
                else if (a == TX_A) push = 1;
                else if (a == ST_A) clr = 1;
            end
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(wd[7:0]);
                    exp_q.push_back(wd[7:0]);
                end else begin
                    oset = 1;
                end
            end
            m_mis = mset ? 1'b1 : (clr ? 1'b0 : m_mis);
            m_ovf = oset ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_cyc = m_cyc + 32'd1;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        logic [31:0] d;
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, rdy, d);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0, 1, 2: return {22'b0, 5'($urandom_range(0, 31)), 5'b0} | 32'h0000_0000 + {25'b0, 5'($urandom_range(0, 31)), 2'b00};
            3:       return CYC_A;
            4, 5:    return TX_A;
            6:       return ST_A;
            7:       return {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
            default: begin
                case ($urandom_range(0, 3))
                    0:       return 32'h0000_03FC;
                    1:       return 32'h0000_0400;
                    2:       return 32'hFFFF_000C;
                    default: return 32'h8000_0000;
                endcase
            end
        endcase
    endfunction

    initial begin
        rst = 1'b1; MMemRead = 0; MMemWrite = 0; DataAddr = 0; WriteMem = 0; tx_ready = 0;
        step(1, 0, 0, 0, 0, 0, g);
        step(1, 0, 0, 0, 0, 0, g);

        // Store then load a RAM word; the neighbour stays clear
        step(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, g);
        step(0, 1, 0, 32'h10, 0, 0, g);
        check32("ram_load", g, 32'hDEAD_BEEF);
        step(0, 1, 0, 32'h14, 0, 0, g);
        check32("ram_neighbour", g, 32'h0);

        // CYCLE counter spacing after a fresh reset
        step(1, 0, 0, 0, 0, 0, g);
        idle(5, 0);
        step(0, 1, 0, CYC_A, 0, 0, g1);
        check32("cycle_at_5", g1, 32'd5);
        idle(2, 0);
        step(0, 1, 0, CYC_A, 0, 0, g2);
        check32("cycle_delta", g2 - g1, 32'd3);

        // Fill FIFO, overflow, then drain in order
        step(0, 0, 1, TX_A, 32'h11, 0, g);
        step(0, 0, 1, TX_A, 32'h22, 0, g);
        step(0, 0, 1, TX_A, 32'h33, 0, g);
        step(0, 0, 1, TX_A, 32'h44, 0, g);
        step(0, 0, 1, TX_A, 32'h55, 0, g);
        step(0, 1, 0, ST_A, 0, 0, g);
        check32("status_ovf_full", g, 32'h4A);
        check32("fault_after_ovf", {31'b0, mem_fault}, 32'd1);
        idle(6, 1);
        check32("drain1_empty", exp_q.size(), 0);

        // Push into a full FIFO on the same edge as a pop
        step(0, 0, 1, ST_A, 0, 0, g);
        step(0, 0, 1, TX_A, 32'hAA, 0, g);
        step(0, 0, 1, TX_A, 32'hBB, 0, g);
        step(0, 0, 1, TX_A, 32'hCC, 0, g);
        step(0, 0, 1, TX_A, 32'hDD, 0, g);
        step(0, 0, 1, TX_A, 32'h66, 1, g);
        step(0, 1, 0, ST_A, 0, 0, g);
        check32("status_push_pop_full", g, 32'h42);
        idle(6, 1);
        check32("drain2_empty", exp_q.size(), 0);

        // Misaligned read, then clear through STATUS
        step(0, 1, 0, 32'h2, 0, 0, g);
        check32("misaligned_rdata", g, 32'h0);
        step(0, 1, 0, ST_A, 0, 0, g);
        check32("status_mis", g, 32'h05);
        step(0, 0, 1, ST_A, 0, 0, g);
        step(0, 1, 0, ST_A, 0, 0, g);
        check32("status_cleared", g, 32'h01);
        check32("fault_cleared", {31'b0, mem_fault}, 32'd0);

        // Reset with data in RAM and FIFO
        step(0, 0, 1, 32'h10, 32'h1234, 0, g);
        step(0, 0, 1, TX_A, 32'h01, 0, g);
        step(0, 0, 1, TX_A, 32'h02, 0, g);
        step(0, 0, 1, TX_A, 32'h03, 0, g);
        step(1, 0, 0, 0, 0, 0, g);
        step(0, 1, 0, ST_A, 0, 1, g);
        check32("status_after_rst", g, 32'h01);
        check32("tx_valid_after_rst", {31'b0, tx_valid}, 32'd0);
        step(0, 1, 0, 32'h10, 0, 1, g);
        check32("ram4_after_rst", g, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 249) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, pick_addr(), $urandom,
                 $urandom_range(0, 2) != 0, g);
        end

        idle(DEPTH + 4, 1);
        check32("final_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
